keycode_lock: RTL and testbench

Sequencing controller that sits behind the two-key debouncer and turns its single-cycle `key0`/`key1` pulses into a code-entry lock. It shifts keyed bits into an entry register and compares the completed entry against a parameterised code. A match produces a timed unlock window. Repeated failures produce a timed alarm lockout. All timeouts are measured in heartbeat ticks, not clock cycles.

---
 rtl/keycode_lock_pkg.sv | 23 ++
 rtl/keycode_lock_if.sv | 26 ++
 rtl/keycode_lock_tick_timer.sv | 26 ++
 rtl/keycode_lock.sv | 140 ++++++++++++++
 tb/tb_keycode_lock.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/keycode_lock_pkg.sv
// Shared types for the code-entry lock: FSM state encoding and timer width helper.
// Used by the lock core and any status/display block that decodes its state.
package keycode_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENTRY,
      ST_CHECK,
      ST_OPEN,
      ST_LOCKOUT
   } kc_state_t;

   // Width needed to count up to the largest of the three tick limits.
   function automatic int tick_cnt_w(input int entry_ticks, input int open_ticks,
                                     input int lock_ticks);
      int m;
      m = entry_ticks;
      if (open_ticks > m) m = open_ticks;
      if (lock_ticks > m) m = lock_ticks;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/keycode_lock_if.sv
// Key/tick inputs and status outputs of the code-entry lock.
// master drives keys and heartbeat; slave is the lock itself.
interface keycode_lock_if #(
   parameter int CODE_W   = 4,
   parameter int MAX_FAIL = 3
) ();
   logic                              tick;
   logic                              key0;
   logic                              key1;
   logic                              clear;
   logic                              unlocked;
   logic                              alarm;
   logic                              err;
   logic [$clog2(CODE_W+1)-1:0]       bit_count;
   logic [$clog2(MAX_FAIL+1)-1:0]     fail_count;

   modport master (
      output tick, key0, key1, clear,
      input  unlocked, alarm, err, bit_count, fail_count
   );

   modport slave (
      input  tick, key0, key1, clear,
      output unlocked, alarm, err, bit_count, fail_count
   );
endinterface

// File: rtl/keycode_lock_tick_timer.sv
// Heartbeat-tick counter: done pulses combinationally on the limit-th tick since clr.
// A tick in a cycle with clr asserted is discarded; the count restarts after done.
module tick_timer #(
   parameter int W = 5
) (
   input  logic         sysclk,
   input  logic         reset,
   input  logic         clr,
   input  logic         tick,
   input  logic [W-1:0] limit,
   output logic         done
);
   logic [W-1:0] cnt;

   assign done = tick && !clr && (cnt == limit - 1'b1);

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr || done) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/keycode_lock.sv
// Code-entry lock: shifts key pulses into an entry, checks it, opens or locks out for tick-timed windows.
// All outputs registered; last key at N gives CHECK at N+1 and unlocked/err/alarm at N+2. No backpressure.
module keycode_lock
   import keycode_pkg::*;
#(
   parameter int               CODE_W      = 4,
   parameter logic [CODE_W-1:0] CODE       = 4'b1011,
   parameter int               MAX_FAIL    = 3,
   parameter int               ENTRY_TICKS = 8,
   parameter int               OPEN_TICKS  = 10,
   parameter int               LOCK_TICKS  = 16
) (
   input  logic           sysclk,
   input  logic           reset,
   keycode_lock_if.slave  bus
);
   localparam int BC_W = $clog2(CODE_W + 1);
   localparam int FC_W = $clog2(MAX_FAIL + 1);
   localparam int TW   = tick_cnt_w(ENTRY_TICKS, OPEN_TICKS, LOCK_TICKS);

   kc_state_t         state;
   logic [CODE_W-1:0] entry;
   logic [BC_W-1:0]   bit_count;
   logic [FC_W-1:0]   fail_count;
   logic              unlocked;
   logic              alarm;
   logic              err;

   logic              valid_key;
   logic              tmr_clr;
   logic              tmr_done;
   logic [TW-1:0]     limit;

   assign valid_key = bus.key0 ^ bus.key1;

   // Timer is held clear outside timed states and restarts on any key or abort.
   assign tmr_clr = (state == ST_IDLE) || (state == ST_CHECK) ||
                    (bus.clear && (state != ST_LOCKOUT)) ||
                    ((state == ST_ENTRY) && valid_key);

   always_comb begin
      limit = '0;
      case (state)
         ST_ENTRY:   limit = TW'(ENTRY_TICKS);
         ST_OPEN:    limit = TW'(OPEN_TICKS);
         ST_LOCKOUT: limit = TW'(LOCK_TICKS);
         default:    limit = '0;
      endcase
   end

   tick_timer #(.W(TW)) u_timer (
      .sysclk (sysclk),
      .reset  (reset),
      .clr    (tmr_clr),
      .tick   (bus.tick),
      .limit  (limit),
      .done   (tmr_done)
   );

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         entry      <= '0;
         bit_count  <= '0;
         fail_count <= '0;
         unlocked   <= 1'b0;
         alarm      <= 1'b0;
         err        <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.clear) begin
                  entry     <= '0;
                  bit_count <= '0;
               end else if (valid_key) begin
                  entry     <= {{(CODE_W-1){1'b0}}, bus.key1};
                  bit_count <= BC_W'(1);
                  state     <= (CODE_W == 1) ? ST_CHECK : ST_ENTRY;
               end
            end
            ST_ENTRY: begin
               if (bus.clear) begin
                  entry     <= '0;
                  bit_count <= '0;
                  state     <= ST_IDLE;
               end else if (valid_key) begin
                  entry     <= {entry[CODE_W-2:0], bus.key1};
                  bit_count <= bit_count + 1'b1;
                  if (bit_count == BC_W'(CODE_W - 1)) state <= ST_CHECK;
               end else if (tmr_done) begin
                  err       <= 1'b1;
                  entry     <= '0;
                  bit_count <= '0;
                  state     <= ST_IDLE;
               end
            end
            ST_CHECK: begin
               entry     <= '0;
               bit_count <= '0;
               if (entry == CODE) begin
                  fail_count <= '0;
                  unlocked   <= 1'b1;
                  state      <= ST_OPEN;
               end else begin
                  err        <= 1'b1;
                  fail_count <= fail_count + 1'b1;
                  if (fail_count == FC_W'(MAX_FAIL - 1)) begin
                     alarm <= 1'b1;
                     state <= ST_LOCKOUT;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            ST_OPEN: begin
               if (bus.clear || tmr_done) begin
                  unlocked <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            ST_LOCKOUT: begin
               // clear is deliberately ignored so an abort cannot shorten the lockout.
               if (tmr_done) begin
                  fail_count <= '0;
                  alarm      <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.unlocked   = unlocked;
   assign bus.alarm      = alarm;
   assign bus.err        = err;
   assign bus.bit_count  = bit_count;
   assign bus.fail_count = fail_count;
endmodule

// File: tb/tb_keycode_lock.sv
// Directed bench for keycode_lock: code match/mismatch, lockout, timeout, clear and async reset.
module tb_keycode_lock;
   import keycode_pkg::*;

   logic sysclk = 1'b0;
   logic reset  = 1'b0;
   int   vec    = 0;
   int   miss   = 0;

   keycode_lock_if #(.CODE_W(4), .MAX_FAIL(3)) bus ();

   keycode_lock dut (
      .sysclk (sysclk),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 sysclk = ~sysclk;

   task automatic step();
      @(negedge sysclk);
   endtask

   task automatic press(input logic b);
      bus.key0 = ~b;
      bus.key1 = b;
      step();
      bus.key0 = 1'b0;
      bus.key1 = 1'b0;
   endtask

   task automatic do_tick();
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
   endtask

   task automatic test_reset();
      bus.tick = 0; bus.key0 = 0; bus.key1 = 0; bus.clear = 0;
      reset = 1'b0;
      repeat (2) step();
      vec++;
      if ({bus.unlocked, bus.alarm, bus.err} !== 3'b000) begin
         miss++; $display("FAIL reset_outs: got %b want 000", {bus.unlocked, bus.alarm, bus.err});
      end
      vec++;
      if (bus.bit_count !== 3'd0 || bus.fail_count !== 2'd0) begin
         miss++; $display("FAIL reset_counts: got bc=%0d fc=%0d want 0/0", bus.bit_count, bus.fail_count);
      end
      reset = 1'b1;
      step();
   endtask

   task automatic test_correct_code();
      press(1'b1);
      vec++;
      if (bus.bit_count !== 3'd1) begin
         miss++; $display("FAIL ok_bc1: got %0d want 1", bus.bit_count);
      end
      repeat (3) step();
      press(1'b0); repeat (3) step();
      press(1'b1); repeat (3) step();
      press(1'b1);
      // Now in CHECK: last key edge has passed, verdict not yet registered.
      vec++;
      if (bus.bit_count !== 3'd4 || bus.unlocked !== 1'b0) begin
         miss++; $display("FAIL ok_check: got bc=%0d unl=%b want 4/0", bus.bit_count, bus.unlocked);
      end
      do_tick(); // tick in the cycle of entry to OPEN must not count
      vec++;
      if (bus.unlocked !== 1'b1 || bus.fail_count !== 2'd0 || bus.err !== 1'b0) begin
         miss++; $display("FAIL ok_open: got unl=%b fc=%0d err=%b want 1/0/0", bus.unlocked, bus.fail_count, bus.err);
      end
      press(1'b1);
      vec++;
      if (bus.bit_count !== 3'd0) begin
         miss++; $display("FAIL open_key_ignored: got bc=%0d want 0", bus.bit_count);
      end
      repeat (9) do_tick();
      vec++;
      if (bus.unlocked !== 1'b1) begin
         miss++; $display("FAIL open_9ticks: got %b want 1", bus.unlocked);
      end
      do_tick();
      vec++;
      if (bus.unlocked !== 1'b0 || dut.state !== ST_IDLE) begin
         miss++; $display("FAIL open_end: got unl=%b st=%0d want 0/%0d", bus.unlocked, dut.state, ST_IDLE);
      end
   endtask

   task automatic wrong_entry(input int expect_fc);
      repeat (4) press(1'b0);
      vec++;
      if (bus.err !== 1'b0) begin
         miss++; $display("FAIL bad_err_early: got %b want 0", bus.err);
      end
      step();
      vec++;
      if (bus.err !== 1'b1 || bus.fail_count !== 2'(expect_fc) || bus.unlocked !== 1'b0) begin
         miss++; $display("FAIL bad_verdict: got err=%b fc=%0d unl=%b want 1/%0d/0", bus.err, bus.fail_count, bus.unlocked, expect_fc);
      end
      step();
      vec++;
      if (bus.err !== 1'b0 || bus.bit_count !== 3'd0) begin
         miss++; $display("FAIL bad_err_pulse: got err=%b bc=%0d want 0/0", bus.err, bus.bit_count);
      end
   endtask

   task automatic test_wrong_code();
      wrong_entry(1);
      vec++;
      if (bus.alarm !== 1'b0) begin
         miss++; $display("FAIL bad1_alarm: got %b want 0", bus.alarm);
      end
      wrong_entry(2);
      wrong_entry(3);
      vec++;
      if (bus.alarm !== 1'b1) begin
         miss++; $display("FAIL lock_alarm: got %b want 1", bus.alarm);
      end
      press(1'b1);
      bus.clear = 1'b1; step(); bus.clear = 1'b0;
      vec++;
      if (bus.bit_count !== 3'd0 || bus.alarm !== 1'b1 || bus.fail_count !== 2'd3) begin
         miss++; $display("FAIL lock_ignore: got bc=%0d al=%b fc=%0d want 0/1/3", bus.bit_count, bus.alarm, bus.fail_count);
      end
      repeat (15) do_tick();
      vec++;
      if (bus.alarm !== 1'b1) begin
         miss++; $display("FAIL lock_15ticks: got %b want 1", bus.alarm);
      end
      do_tick();
      vec++;
      if (bus.alarm !== 1'b0 || bus.fail_count !== 2'd0) begin
         miss++; $display("FAIL lock_end: got al=%b fc=%0d want 0/0", bus.alarm, bus.fail_count);
      end
   endtask

   task automatic test_timeout();
      wrong_entry(1);
      press(1'b1); press(1'b0);
      repeat (7) do_tick();
      vec++;
      if (bus.err !== 1'b0 || bus.bit_count !== 3'd2) begin
         miss++; $display("FAIL to_7ticks: got err=%b bc=%0d want 0/2", bus.err, bus.bit_count);
      end
      do_tick();
      vec++;
      if (bus.err !== 1'b1 || bus.bit_count !== 3'd0 || bus.fail_count !== 2'd1) begin
         miss++; $display("FAIL to_fire: got err=%b bc=%0d fc=%0d want 1/0/1", bus.err, bus.bit_count, bus.fail_count);
      end
      step();
      vec++;
      if (bus.err !== 1'b0 || dut.state !== ST_IDLE) begin
         miss++; $display("FAIL to_after: got err=%b st=%0d want 0/%0d", bus.err, dut.state, ST_IDLE);
      end
   endtask

   task automatic test_simultaneous();
      bus.key0 = 1; bus.key1 = 1; step(); bus.key0 = 0; bus.key1 = 0;
      vec++;
      if (bus.bit_count !== 3'd0 || dut.state !== ST_IDLE) begin
         miss++; $display("FAIL both_idle: got bc=%0d st=%0d want 0/%0d", bus.bit_count, dut.state, ST_IDLE);
      end
      press(1'b1);
      bus.key0 = 1; bus.key1 = 1; step(); bus.key0 = 0; bus.key1 = 0;
      vec++;
      if (bus.bit_count !== 3'd1) begin
         miss++; $display("FAIL both_entry: got bc=%0d want 1", bus.bit_count);
      end
      repeat (5) do_tick();
      bus.tick = 1; bus.key1 = 1; step(); bus.tick = 0; bus.key1 = 0;
      repeat (7) do_tick();
      vec++;
      if (bus.err !== 1'b0 || bus.bit_count !== 3'd2) begin
         miss++; $display("FAIL tickkey_restart: got err=%b bc=%0d want 0/2", bus.err, bus.bit_count);
      end
      do_tick();
      vec++;
      if (bus.err !== 1'b1 || bus.bit_count !== 3'd0) begin
         miss++; $display("FAIL tickkey_timeout: got err=%b bc=%0d want 1/0", bus.err, bus.bit_count);
      end
      step();
   endtask

   task automatic test_clear();
      wrong_entry(2);
      press(1'b1); press(1'b0); press(1'b1);
      vec++;
      if (bus.bit_count !== 3'd3) begin
         miss++; $display("FAIL clr_pre: got bc=%0d want 3", bus.bit_count);
      end
      bus.clear = 1; bus.key1 = 1; bus.tick = 1; step();
      bus.clear = 0; bus.key1 = 0; bus.tick = 0;
      vec++;
      if (bus.bit_count !== 3'd0 || bus.fail_count !== 2'd2 || dut.state !== ST_IDLE) begin
         miss++; $display("FAIL clr_entry: got bc=%0d fc=%0d st=%0d want 0/2/%0d", bus.bit_count, bus.fail_count, dut.state, ST_IDLE);
      end
   endtask

   task automatic test_async_reset();
      press(1'b1); press(1'b0); press(1'b1); press(1'b1);
      step();
      vec++;
      if (bus.unlocked !== 1'b1 || bus.fail_count !== 2'd0) begin
         miss++; $display("FAIL ar_open: got unl=%b fc=%0d want 1/0", bus.unlocked, bus.fail_count);
      end
      #2 reset = 1'b0;
      #1;
      vec++;
      if (bus.unlocked !== 1'b0) begin
         miss++; $display("FAIL ar_immediate: got %b want 0", bus.unlocked);
      end
      step();
      reset = 1'b1;
      step();
      vec++;
      if (dut.state !== ST_IDLE || bus.bit_count !== 3'd0 || bus.unlocked !== 1'b0) begin
         miss++; $display("FAIL ar_release: got st=%0d bc=%0d unl=%b want %0d/0/0", dut.state, bus.bit_count, bus.unlocked, ST_IDLE);
      end
      press(1'b0);
      vec++;
      if (bus.bit_count !== 3'd1) begin
         miss++; $display("FAIL ar_resume: got bc=%0d want 1", bus.bit_count);
      end
   endtask

   initial begin
      test_reset();
      test_correct_code();
      test_wrong_code();
      test_timeout();
      test_simultaneous();
      test_clear();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
